// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and opcode decode helper for alu_seq.
package alu_pkg;

    localparam logic [2:0] OP_LOGIC  = 3'b000;
    localparam logic [2:0] OP_ADDSUB = 3'b011;
    localparam logic [2:0] OP_SHIFT  = 3'b100;
    localparam logic [2:0] OP_MUL    = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_LOGIC) || (op == OP_ADDSUB) || (op == OP_SHIFT) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/adder_n.sv
// WIDTH-bit ripple-style adder with carry-in and carry-out.
module adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    assign {Cout, S} = (WIDTH+1)'(A) + (WIDTH+1)'(B) + (WIDTH+1)'(cin);

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/add/sub, iterative shift and shift-add
// multiply, with a valid/ready request side and a held result side.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [2:0]       ctrl,
    input  logic             flag,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             zero,
    output logic             illegal,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned CW_MUL = $clog2(WIDTH + 1);
    localparam int unsigned CW     = (SHW + 1 > CW_MUL) ? SHW + 1 : CW_MUL;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, m_q;
    logic [CW-1:0]    cnt_q;
    logic             mul_q, shl_q;
    logic [WIDTH-1:0] out_q;
    logic             ovf_q, zero_q, ill_q, in_ready_q, out_valid_q;

    logic             add_cin, add_cout;
    logic [WIDTH-1:0] add_a, add_b, add_s;
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH-1:0] res_c, acc_n, m_n, sh_n, fin_c;
    logic             ovf_c, ill_c, go_busy_c, fin_ovf_c;

    assign sh_amt = rs2[SHW-1:0];

    // One adder serves add/sub on accept and the multiply accumulate in BUSY.
    always_comb begin
        add_cin = 1'b0;
        add_a   = rs1;
        add_b   = rs2;
        if (state_q == ST_BUSY) begin
            add_a = a_q;
            add_b = m_q[0] ? b_q : '0;
        end else if (flag) begin
            add_b   = ~rs2;
            add_cin = 1'b1;
        end
    end

    adder_n #(.WIDTH(WIDTH)) u_adder (
        .cin  (add_cin),
        .A    (add_a),
        .B    (add_b),
        .S    (add_s),
        .Cout (add_cout)
    );

    // Result of an accepted request that completes without BUSY cycles.
    always_comb begin
        res_c     = '0;
        ovf_c     = 1'b0;
        ill_c     = !op_is_legal(ctrl);
        go_busy_c = 1'b0;
        case (ctrl)
            OP_LOGIC:  res_c = flag ? ~(rs1 & rs2) : ~(rs1 | rs2);
            OP_ADDSUB: begin
                res_c = add_s;
                ovf_c = add_cout;
            end
            OP_SHIFT:  begin
                res_c     = rs1;
                go_busy_c = (sh_amt != '0);
            end
            OP_MUL:    go_busy_c = 1'b1;
            default:   res_c = '0;
        endcase
    end

    // One iteration step: {carry, acc, multiplier} shifts right; shifter moves one bit.
    assign acc_n     = {add_cout, add_s[WIDTH-1:1]};
    assign m_n       = {add_s[0], m_q[WIDTH-1:1]};
    assign sh_n      = shl_q ? {a_q[WIDTH-2:0], 1'b0} : {1'b0, a_q[WIDTH-1:1]};
    assign fin_c     = mul_q ? m_n : sh_n;
    assign fin_ovf_c = mul_q && (acc_n != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            m_q         <= '0;
            cnt_q       <= '0;
            mul_q       <= 1'b0;
            shl_q       <= 1'b0;
            out_q       <= '0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b1;
            ill_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid) begin
                    in_ready_q <= 1'b0;
                    a_q        <= (ctrl == OP_MUL) ? '0 : rs1;
                    b_q        <= rs1;
                    m_q        <= rs2;
                    mul_q      <= (ctrl == OP_MUL);
                    shl_q      <= flag;
                    cnt_q      <= (ctrl == OP_MUL) ? CW'(WIDTH) : CW'(sh_amt);
                    if (go_busy_c) begin
                        state_q <= ST_BUSY;
                    end else begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        out_q       <= res_c;
                        ovf_q       <= ovf_c;
                        zero_q      <= (res_c == '0);
                        ill_q       <= ill_c;
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q - CW'(1);
                    a_q   <= mul_q ? acc_n : sh_n;
                    if (mul_q) m_q <= m_n;
                    if (cnt_q == CW'(1)) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        out_q       <= fin_c;
                        ovf_q       <= fin_ovf_c;
                        zero_q      <= (fin_c == '0);
                        ill_q       <= 1'b0;
                    end
                end
                ST_DONE: if (out_ready) begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out       = out_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign illegal   = ill_q;
    assign out_valid = out_valid_q;

endmodule
